// File: rtl/tile_mac_sequencer.sv
// rtl/tile_mac_sequencer.sv - row sequencer that MACs x/w pairs into per-tile dot products
module tile_mac_sequencer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 64,
  parameter int TILE_SIZE = 4,
  parameter int NUM_TILES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  x_in,
  input  logic [IN_WIDTH-1:0]  w_in,
  output logic                 acc_clear,
  output logic                 tile_valid,
  output logic [OUT_WIDTH-1:0] tile_sum,
  output logic                 busy,
  output logic                 row_done
);

  localparam int EW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [EW-1:0]                elem_cnt;
  logic [TW-1:0]                tile_cnt;
  logic signed [OUT_WIDTH-1:0]  partial;
  logic signed [2*IN_WIDTH-1:0] product;
  logic signed [OUT_WIDTH-1:0]  product_ext;
  logic                         last_elem;
  logic                         last_tile;

  // Full-precision signed product, then sign-extended into the wrapping accumulator width.
  assign product     = $signed(x_in) * $signed(w_in);
  assign product_ext = OUT_WIDTH'(product);
  assign last_elem   = (elem_cnt == EW'(TILE_SIZE - 1));
  assign last_tile   = (tile_cnt == TW'(NUM_TILES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    acc_clear  = 1'b0;
    tile_valid = 1'b0;
    row_done   = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !abort) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clear = 1'b1;
        state_nxt = S_MAC;
      end
      S_MAC: begin
        in_ready = 1'b1;
        if (in_valid && last_elem) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        tile_valid = 1'b1;
        state_nxt  = last_tile ? S_DONE : S_MAC;
      end
      S_DONE: begin
        row_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // tile_sum is only written on the transfer that closes a tile, so it survives aborts and bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= '0;
      tile_cnt <= '0;
      partial  <= '0;
      tile_sum <= '0;
    end else if (abort && state != S_IDLE) begin
      elem_cnt <= '0;
      tile_cnt <= '0;
      partial  <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          elem_cnt <= '0;
          tile_cnt <= '0;
          partial  <= '0;
        end
        S_MAC: begin
          if (in_valid) begin
            if (last_elem) begin
              tile_sum <= partial + product_ext;
              partial  <= '0;
              elem_cnt <= '0;
            end else begin
              partial  <= partial + product_ext;
              elem_cnt <= elem_cnt + EW'(1);
            end
          end
        end
        S_EMIT: begin
          if (!last_tile) tile_cnt <= tile_cnt + TW'(1);
        end
        S_DONE: begin
          tile_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_mac_sequencer.sv
// tb/tb_tile_mac_sequencer.sv - scoreboard bench for tile_mac_sequencer
module tb_tile_mac_sequencer;
  localparam int IW = 16;
  localparam int OW = 64;
  localparam int TS = 4;
  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] x_in = '0;
  logic [IW-1:0] w_in = '0;
  logic          acc_clear;
  logic          tile_valid;
  logic [OW-1:0] tile_sum;
  logic          busy;
  logic          row_done;

  tile_mac_sequencer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .TILE_SIZE(TS), .NUM_TILES(NT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
    .acc_clear(acc_clear), .tile_valid(tile_valid), .tile_sum(tile_sum),
    .busy(busy), .row_done(row_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [OW-1:0] exp_tile_q[$];
  logic [OW-1:0] exp_row_q[$];
  logic [OW-1:0] acc = '0;
  int n_clear, n_tile, n_done;
  int cyc = 0;
  int start_cyc, done_cyc;
  logic [IW-1:0] xs [8];
  logic [IW-1:0] ws [8];

  localparam logic [OW-1:0] NEG12 = 64'hFFFF_FFFF_FFFF_FFF4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor also models the downstream accumulator fed by acc_clear/tile_valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_clear) begin
        acc = '0;
        n_clear++;
      end
      if (tile_valid) begin
        n_tile++;
        acc = acc + tile_sum;
        if (exp_tile_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tile_valid: got tile_sum %h expected no pulse", tile_sum);
        end else begin
          check("tile_sum", tile_sum, exp_tile_q.pop_front());
        end
      end
      if (row_done) begin
        n_done++;
        done_cyc = cyc;
        if (exp_row_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_row_done: got acc %h expected no pulse", acc);
        end else begin
          check("acc_sum", acc, exp_row_q.pop_front());
        end
      end
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic send(input logic [IW-1:0] x, input logic [IW-1:0] w, input bit bubble, input bit pulse_start);
    int  n;
    bit  ok;
    if (bubble) begin
      in_valid = 1'b0;
      @(negedge clk);
      check("in_ready_in_bubble", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    x_in = x;
    w_in = w;
    start = pulse_start;
    n = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    in_valid = 1'b0;
    start = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected 1", n);
    end
  endtask

  task automatic wait_row_done();
    int k = 0;
    while (n_done == 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  task automatic run_row(input bit bubbles, input logic [OW-1:0] e0, input logic [OW-1:0] e1,
                         input logic [OW-1:0] eacc, input string tag);
    n_clear = 0;
    n_tile  = 0;
    n_done  = 0;
    exp_tile_q.push_back(e0);
    exp_tile_q.push_back(e1);
    exp_row_q.push_back(eacc);
    do_start();
    for (int i = 0; i < 2 * TS; i++) send(xs[i], ws[i], bubbles && (i % TS) != 0, 1'b0);
    wait_row_done();
    check({tag, "_acc_clear_count"}, 64'(n_clear), 64'd1);
    check({tag, "_tile_valid_count"}, 64'(n_tile), 64'd2);
    check({tag, "_row_done_count"}, 64'(n_done), 64'd1);
    if (!bubbles) check({tag, "_latency"}, 64'(done_cyc - start_cyc), 64'(NT * (TS + 1) + 1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_acc_clear"}, 64'(acc_clear), 64'd0);
    check({tag, "_tile_valid"}, 64'(tile_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_row_done"}, 64'(row_done), 64'd0);
    check({tag, "_tile_sum"}, tile_sum, 64'd0);
  endtask

  task automatic load_basic();
    xs = '{16'd1, 16'd2, 16'd3, 16'd4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    ws = '{16'd2, 16'd2, 16'd2, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 check_idle_outputs("reset");
    rst_n = 1'b1;

    load_basic();
    run_row(1'b0, 64'd20, NEG12, 64'd8, "basic");
    repeat (3) @(posedge clk);
    #1 check("tile_sum_hold", tile_sum, NEG12);

    run_row(1'b1, 64'd20, NEG12, 64'd8, "bubbles");

    xs = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0};
    ws = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0};
    run_row(1'b0, 64'h0000_0001_0000_0000, 64'd0, 64'h0000_0001_0000_0000, "minval");

    // start pulsed mid-row is ignored; abort two elements into tile 1
    load_basic();
    n_clear = 0;
    n_tile  = 0;
    n_done  = 0;
    exp_tile_q.push_back(64'd20);
    do_start();
    for (int i = 0; i < TS + 2; i++) send(xs[i], ws[i], 1'b0, i == 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_tile_valid_count", 64'(n_tile), 64'd1);
    check("abort_row_done_count", 64'(n_done), 64'd0);
    check("abort_acc_clear_count", 64'(n_clear), 64'd1);
    check("abort_tile_sum_hold", tile_sum, 64'd20);
    run_row(1'b0, 64'd20, NEG12, 64'd8, "after_abort");

    // asynchronous reset in the middle of tile 0
    do_start();
    send(xs[0], ws[0], 1'b0, 1'b0);
    send(xs[1], ws[1], 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midrow_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_row(1'b0, 64'd20, NEG12, 64'd8, "after_reset");

    repeat (3) @(posedge clk);
    #1;
    check("tile_queue_drained", 64'(exp_tile_q.size()), 64'd0);
    check("row_queue_drained", 64'(exp_row_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
